// File: rtl/alu_ctrl_seq_pkg.sv
// Shared opcode, funct and ALU control encodings for the ALU control unit.
// Also holds the decoder result payload and the sequencer state type.
package alu_ctrl_seq_pkg;

    localparam int unsigned FUNCT_W = 6;
    localparam int unsigned OPC_W   = 3;
    localparam int unsigned CODE_W  = 4;

    localparam logic [OPC_W-1:0] ALUOP_ADD   = 3'b000;
    localparam logic [OPC_W-1:0] ALUOP_SUB   = 3'b001;
    localparam logic [OPC_W-1:0] ALUOP_RTYPE = 3'b010;
    localparam logic [OPC_W-1:0] ALUOP_AND   = 3'b011;
    localparam logic [OPC_W-1:0] ALUOP_OR    = 3'b100;
    localparam logic [OPC_W-1:0] ALUOP_SLT   = 3'b101;

    localparam logic [FUNCT_W-1:0] FUNCT_ADD  = 6'b100000;
    localparam logic [FUNCT_W-1:0] FUNCT_SUB  = 6'b100010;
    localparam logic [FUNCT_W-1:0] FUNCT_AND  = 6'b100100;
    localparam logic [FUNCT_W-1:0] FUNCT_OR   = 6'b100101;
    localparam logic [FUNCT_W-1:0] FUNCT_SLT  = 6'b101010;
    localparam logic [FUNCT_W-1:0] FUNCT_NOR  = 6'b100111;
    localparam logic [FUNCT_W-1:0] FUNCT_MULT = 6'b011000;
    localparam logic [FUNCT_W-1:0] FUNCT_DIV  = 6'b011010;

    localparam logic [CODE_W-1:0] CTRL_AND     = 4'b0000;
    localparam logic [CODE_W-1:0] CTRL_OR      = 4'b0001;
    localparam logic [CODE_W-1:0] CTRL_ADD     = 4'b0010;
    localparam logic [CODE_W-1:0] CTRL_SUB     = 4'b0110;
    localparam logic [CODE_W-1:0] CTRL_SLT     = 4'b0111;
    localparam logic [CODE_W-1:0] CTRL_MULT    = 4'b1000;
    localparam logic [CODE_W-1:0] CTRL_DIV     = 4'b1001;
    localparam logic [CODE_W-1:0] CTRL_NOR     = 4'b1100;
    localparam logic [CODE_W-1:0] CTRL_ILLEGAL = 4'b1111;

    typedef struct packed {
        logic [CODE_W-1:0] code;
        logic              illegal;
        logic              is_md;
    } dec_t;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_MD_WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Pure combinational funct/ALUOp decode into {code, illegal, is_md}.
// MULT/DIV are always recognised here; the sequencer decides whether they are supported.
module alu_ctrl_decode
    import alu_ctrl_seq_pkg::*;
#(
    parameter int unsigned ALUOP_W = 3
) (
    input  logic [FUNCT_W-1:0] i_funct,
    input  logic [ALUOP_W-1:0] i_aluop,
    output dec_t               o_dec_c
);

    always_comb begin
        o_dec_c = '{code: CTRL_ILLEGAL, illegal: 1'b1, is_md: 1'b0};
        case (i_aluop)
            ALUOP_W'(ALUOP_ADD): o_dec_c = '{code: CTRL_ADD, illegal: 1'b0, is_md: 1'b0};
            ALUOP_W'(ALUOP_SUB): o_dec_c = '{code: CTRL_SUB, illegal: 1'b0, is_md: 1'b0};
            ALUOP_W'(ALUOP_AND): o_dec_c = '{code: CTRL_AND, illegal: 1'b0, is_md: 1'b0};
            ALUOP_W'(ALUOP_OR):  o_dec_c = '{code: CTRL_OR,  illegal: 1'b0, is_md: 1'b0};
            ALUOP_W'(ALUOP_SLT): o_dec_c = '{code: CTRL_SLT, illegal: 1'b0, is_md: 1'b0};
            ALUOP_W'(ALUOP_RTYPE): begin
                // funct only matters for R-type ops
                case (i_funct)
                    FUNCT_ADD:  o_dec_c = '{code: CTRL_ADD,  illegal: 1'b0, is_md: 1'b0};
                    FUNCT_SUB:  o_dec_c = '{code: CTRL_SUB,  illegal: 1'b0, is_md: 1'b0};
                    FUNCT_AND:  o_dec_c = '{code: CTRL_AND,  illegal: 1'b0, is_md: 1'b0};
                    FUNCT_OR:   o_dec_c = '{code: CTRL_OR,   illegal: 1'b0, is_md: 1'b0};
                    FUNCT_SLT:  o_dec_c = '{code: CTRL_SLT,  illegal: 1'b0, is_md: 1'b0};
                    FUNCT_NOR:  o_dec_c = '{code: CTRL_NOR,  illegal: 1'b0, is_md: 1'b0};
                    FUNCT_MULT: o_dec_c = '{code: CTRL_MULT, illegal: 1'b0, is_md: 1'b1};
                    FUNCT_DIV:  o_dec_c = '{code: CTRL_DIV,  illegal: 1'b0, is_md: 1'b1};
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Registered, handshaked ALU control unit with optional MULT/DIV sequencing.
// Define ALU_CTRL_MULDIV_EN to build the MD_WAIT state, busy counter and mul/div launch.
module alu_ctrl_seq
    import alu_ctrl_seq_pkg::*;
#(
    parameter int unsigned ALUOP_W   = 3,
    parameter int unsigned CTRL_W    = 4,
    parameter int unsigned MD_CYCLES = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [FUNCT_W-1:0] funct_i,
    input  logic [ALUOP_W-1:0] ALUOp_i,
    output logic [CTRL_W-1:0]  ALUCtrl_o,
    output logic               valid_o,
    input  logic               ready_i,
    output logic               illegal_o,
    output logic               md_start_o,
    output logic               busy_o
);

    if (MD_CYCLES < 2) begin : g_bad_md_cycles
        $error("alu_ctrl_seq: MD_CYCLES must be at least 2");
    end

    dec_t              w_dec;
    logic              w_ready;
    logic              w_accept;
    logic [CTRL_W-1:0] r_ctrl;
    logic [CTRL_W-1:0] w_nxt_ctrl;
    logic              r_valid;
    logic              w_nxt_valid;
    logic              r_illegal;
    logic              w_nxt_illegal;

    alu_ctrl_decode #(
        .ALUOP_W (ALUOP_W)
    ) u_decode (
        .i_funct (funct_i),
        .i_aluop (ALUOp_i),
        .o_dec_c (w_dec)
    );

`ifdef ALU_CTRL_MULDIV_EN
    localparam int unsigned CNT_W = $clog2(MD_CYCLES + 1);

    state_e            r_state;
    state_e            w_nxt_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_nxt_cnt;
    logic [CTRL_W-1:0] r_md_ctrl;
    logic [CTRL_W-1:0] w_nxt_md_ctrl;
    logic              r_md_start;
    logic              w_nxt_md_start;
    logic              r_busy;
    logic              w_nxt_busy;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_md_ctrl  <= '0;
            r_md_start <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_nxt_state;
            r_cnt      <= w_nxt_cnt;
            r_md_ctrl  <= w_nxt_md_ctrl;
            r_md_start <= w_nxt_md_start;
            r_busy     <= w_nxt_busy;
        end
    end

    // Next state, handshake and output payload; MD ops park their code until the counter expires
    always_comb begin
        w_ready        = (r_state == ST_IDLE) && (!r_valid || ready_i);
        w_accept       = valid_i && w_ready;
        w_nxt_state    = r_state;
        w_nxt_cnt      = r_cnt;
        w_nxt_md_ctrl  = r_md_ctrl;
        w_nxt_md_start = 1'b0;
        w_nxt_busy     = r_busy;
        w_nxt_ctrl     = r_ctrl;
        w_nxt_illegal  = r_illegal;
        w_nxt_valid    = r_valid && !ready_i;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_dec.is_md) begin
                        w_nxt_state    = ST_MD_WAIT;
                        w_nxt_cnt      = CNT_W'(MD_CYCLES - 1);
                        w_nxt_md_ctrl  = CTRL_W'(w_dec.code);
                        w_nxt_md_start = 1'b1;
                        w_nxt_busy     = 1'b1;
                    end else begin
                        w_nxt_ctrl    = CTRL_W'(w_dec.code);
                        w_nxt_illegal = w_dec.illegal;
                        w_nxt_valid   = 1'b1;
                    end
                end
            end
            ST_MD_WAIT: begin
                w_nxt_cnt = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_nxt_state   = ST_IDLE;
                    w_nxt_ctrl    = r_md_ctrl;
                    w_nxt_illegal = 1'b0;
                    w_nxt_valid   = 1'b1;
                    w_nxt_busy    = 1'b0;
                end
            end
            default: w_nxt_state = ST_IDLE;
        endcase
    end

    assign md_start_o = r_md_start;
    assign busy_o     = r_busy;
`else
    // Without the sequencer, MULT/DIV are reported as undecodable
    always_comb begin
        w_ready       = !r_valid || ready_i;
        w_accept      = valid_i && w_ready;
        w_nxt_ctrl    = r_ctrl;
        w_nxt_illegal = r_illegal;
        w_nxt_valid   = r_valid && !ready_i;
        if (w_accept) begin
            w_nxt_ctrl    = w_dec.is_md ? CTRL_W'(CTRL_ILLEGAL) : CTRL_W'(w_dec.code);
            w_nxt_illegal = w_dec.illegal || w_dec.is_md;
            w_nxt_valid   = 1'b1;
        end
    end

    assign md_start_o = 1'b0;
    assign busy_o     = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_ctrl    <= '0;
            r_valid   <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_ctrl    <= w_nxt_ctrl;
            r_valid   <= w_nxt_valid;
            r_illegal <= w_nxt_illegal;
        end
    end

    assign ready_o   = w_ready;
    assign ALUCtrl_o = r_ctrl;
    assign valid_o   = r_valid;
    assign illegal_o = r_illegal;

endmodule
